// File: rtl/spi_slave_if_pkg.sv
// Shared definitions for the SPI slave front end: mode-0 framing constants and
// the command opcodes the downstream decoder dispatches on.
package spi_slave_if_pkg;

  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;
  localparam int   SPI_BITS = 8;
  localparam int   BITCNT_W = $clog2(SPI_BITS);

  typedef enum logic [7:0] {
    SET_LED          = 8'd0,
    BRAM_POKE        = 8'd1,
    BRAM_PEEK        = 8'd2,
    DBUS_READ        = 8'd3,
    DBUS_WRITE       = 8'd4,
    DATA_READY       = 8'd5,
    SET_BREAKPOINT   = 8'd6,
    CLEAR_BREAKPOINT = 8'd7
  } spi_cmd_e;

endpackage

// File: rtl/spi_slave_if_if.sv
// Byte-level link between the SPI front end and the command decoder.
// Strobes are single-cycle, no back-pressure: the decoder must accept every
// rx_valid, and must present the next reply on tx_data before tx_load fires.
interface spi_slave_if_if
  import spi_slave_if_pkg::*;
#(
  parameter int IDX_W = 8
);
  logic                rx_valid;
  logic [SPI_BITS-1:0] rx_data;
  logic                rx_first;
  logic [IDX_W-1:0]    byte_idx;
  logic [SPI_BITS-1:0] tx_data;
  logic                tx_load;
  logic                frame_start;
  logic                frame_end;
  logic                frame_abort;

  // master: the SPI front end; slave: the command decoder
  modport master (
    output rx_valid, rx_data, rx_first, byte_idx, tx_load,
           frame_start, frame_end, frame_abort,
    input  tx_data
  );

  modport slave (
    input  rx_valid, rx_data, rx_first, byte_idx, tx_load,
           frame_start, frame_end, frame_abort,
    output tx_data
  );
endinterface

// File: rtl/spi_slave_if_pin_sync_edge.sv
// N-stage synchroniser for one asynchronous pin, plus a history flop so that
// rise/fall pulses come out one cycle wide.
module pin_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], pin};
    hist_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign lvl  = sync_q[STAGES-1];
  assign rise = lvl & ~hist_q;
  assign fall = ~lvl & hist_q;

endmodule

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave front end: oversamples SCK/CS/MOSI on clk, emits received
// bytes as strobes with frame position, and shifts reply bytes out on MISO.
module spi_slave_if
  import spi_slave_if_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int IDX_W       = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic SCK,
  input  logic MOSI,
  input  logic CS,
  output logic MISO,
  output logic miso_oe,
  spi_slave_if_if.master bus
);

  localparam int FILL_W = $clog2(SYNC_STAGES + 2);
  localparam logic [BITCNT_W-1:0] BIT_LAST = BITCNT_W'(SPI_BITS - 1);

  logic sck_lvl_unused, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

  pin_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clk(clk), .reset(reset), .pin(SCK),
    .lvl(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall)
  );

  pin_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .reset(reset), .pin(CS),
    .lvl(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  pin_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .reset(reset), .pin(MOSI),
    .lvl(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  logic [FILL_W-1:0]   fill_q, fill_d;
  logic                armed_q, armed_d;
  logic [BITCNT_W-1:0] bitcnt_q, bitcnt_d;
  logic [IDX_W-1:0]    byte_idx_q, byte_idx_d;
  logic [SPI_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [SPI_BITS-1:0] rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                rx_first_q, rx_first_d;
  logic [SPI_BITS-1:0] tx_shift_q, tx_shift_d;

  logic fill_done, cs_active;
  logic frame_start, frame_end, frame_abort;
  logic sck_rise_act, sck_fall_act, tx_load;
  logic [SPI_BITS-1:0] rx_byte;

  // The CS pipeline resets to "idle high"; it only counts as a real CS level
  // once every stage holds a post-reset pin sample, otherwise a CS held low
  // through reset would look like a fresh assertion.
  assign fill_done = (fill_q == FILL_W'(SYNC_STAGES));

  assign cs_active    = armed_q & ~cs_lvl;
  assign frame_start  = armed_q & cs_fall;
  assign frame_end    = armed_q & cs_rise;
  assign frame_abort  = frame_end & (bitcnt_q != '0);
  assign sck_rise_act = sck_rise & cs_active & ~frame_start;
  assign sck_fall_act = sck_fall & cs_active & ~frame_start;
  assign tx_load      = frame_start | (sck_fall_act & (bitcnt_q == '0));
  assign rx_byte      = {rx_shift_q[SPI_BITS-2:0], mosi_lvl};

  always_comb begin
    fill_d     = fill_done ? fill_q : fill_q + FILL_W'(1);
    armed_d    = armed_q | (cs_lvl & fill_done);
    bitcnt_d   = bitcnt_q;
    byte_idx_d = byte_idx_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_first_d = 1'b0;
    tx_shift_d = tx_shift_q;

    if (frame_start) begin
      bitcnt_d   = '0;
      byte_idx_d = '0;
      tx_shift_d = bus.tx_data;
    end else begin
      if (sck_rise_act) begin
        rx_shift_d = rx_byte;
        bitcnt_d   = bitcnt_q + BITCNT_W'(1);
        if (bitcnt_q == BIT_LAST) begin
          rx_data_d  = rx_byte;
          rx_valid_d = 1'b1;
          rx_first_d = (byte_idx_q == '0);
          if (byte_idx_q != '1) byte_idx_d = byte_idx_q + IDX_W'(1);
        end
      end
      if (sck_fall_act) begin
        if (bitcnt_q == '0) tx_shift_d = bus.tx_data;
        else                tx_shift_d = {tx_shift_q[SPI_BITS-2:0], 1'b0};
      end
      // A partial byte at CS release is simply dropped
      if (frame_end) bitcnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fill_q     <= '0;
      armed_q    <= 1'b0;
      bitcnt_q   <= '0;
      byte_idx_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_first_q <= 1'b0;
      tx_shift_q <= '0;
    end else begin
      fill_q     <= fill_d;
      armed_q    <= armed_d;
      bitcnt_q   <= bitcnt_d;
      byte_idx_q <= byte_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_first_q <= rx_first_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  assign MISO             = tx_shift_q[SPI_BITS-1];
  assign miso_oe          = cs_active;
  assign bus.rx_valid     = rx_valid_q;
  assign bus.rx_data      = rx_data_q;
  assign bus.rx_first     = rx_first_q;
  assign bus.byte_idx     = byte_idx_q;
  assign bus.tx_load      = tx_load;
  assign bus.frame_start  = frame_start;
  assign bus.frame_end    = frame_end;
  assign bus.frame_abort  = frame_abort;

endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: drives SPI mode-0 frames at SCK = clk/10 and checks
// received bytes, frame events and MISO reply bits against its own model.
module tb_spi_slave_if;

  localparam int IDX_W   = 8;
  localparam int IDX_MAX = (1 << IDX_W) - 1;

  int errors = 0;
  int checks = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic SCK = 1'b0;
  logic MOSI = 1'b0;
  logic CS = 1'b1;
  logic MISO, miso_oe;

  spi_slave_if_if #(.IDX_W(IDX_W)) bus ();

  spi_slave_if #(.SYNC_STAGES(2), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .SCK(SCK), .MOSI(MOSI), .CS(CS),
    .MISO(MISO), .miso_oe(miso_oe), .bus(bus)
  );

  always #5 clk = ~clk;

  // {rx_first, byte_idx, rx_data} expected per received byte
  logic [16:0] exp_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  fr_d[$];
  logic [7:0]  fr_r[$];
  int n_start = 0, n_end = 0, n_abort = 0, n_rx = 0;
  int n_overlap = 0, n_abort_alone = 0;
  logic tx_load_seen = 1'b0;

  typedef struct {
    int         n;
    logic [7:0] d0, d1, d2;
    int         tail;
    int         exp_rx;
    int         exp_abort;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    logic [16:0] e;
    tx_load_seen = bus.tx_load;
    if (bus.frame_start) n_start++;
    if (bus.frame_end) n_end++;
    if (bus.frame_abort) n_abort++;
    if (bus.frame_abort && !bus.frame_end) n_abort_alone++;
    if (bus.rx_valid && bus.tx_load) n_overlap++;
    if (bus.rx_valid) begin
      n_rx++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected: got byte %0h with nothing expected", bus.rx_data);
      end else begin
        e = exp_q.pop_front();
        check("rx_byte", {bus.rx_first, bus.byte_idx, bus.rx_data}, e);
      end
    end
  end

  // All time passes through here so that reply bytes follow each tx_load
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (tx_load_seen) bus.tx_data = (tx_q.size() != 0) ? tx_q.pop_front() : 8'($urandom);
    end
  endtask

  task automatic sck_bit(input logic b, input logic exp_miso, input bit chk);
    MOSI = b;
    cyc(5);
    if (chk) begin
      check("miso_bit", MISO, exp_miso);
      check("miso_oe_in_frame", miso_oe, 1'b1);
    end
    SCK = 1'b1;
    cyc(5);
    SCK = 1'b0;
  endtask

  task automatic send_frame(input int tail);
    int n;
    n = fr_d.size();
    bus.tx_data = fr_r[0];
    tx_q.delete();
    for (int i = 1; i < fr_r.size(); i++) tx_q.push_back(fr_r[i]);
    CS = 1'b0;
    cyc(6);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 8; i++) begin
        if (i == 7)
          exp_q.push_back({(k == 0), IDX_W'((k + 1 > IDX_MAX) ? IDX_MAX : k + 1), fr_d[k]});
        sck_bit(fr_d[k][7-i], fr_r[k][7-i], 1'b1);
      end
    end
    for (int t = 0; t < tail; t++) sck_bit(1'($urandom), fr_r[n][7-t], 1'b1);
    cyc(4);
    CS = 1'b1;
    cyc(8);
  endtask

  task automatic fill_random(input int n);
    fr_d.delete();
    fr_r.delete();
    for (int i = 0; i < n; i++) fr_d.push_back(8'($urandom));
    for (int i = 0; i <= n; i++) fr_r.push_back(8'($urandom));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_valid"}, bus.rx_valid, 1'b0);
    check({tag, "_tx_load"}, bus.tx_load, 1'b0);
    check({tag, "_frame_start"}, bus.frame_start, 1'b0);
    check({tag, "_frame_end"}, bus.frame_end, 1'b0);
    check({tag, "_frame_abort"}, bus.frame_abort, 1'b0);
    check({tag, "_miso"}, MISO, 1'b0);
    check({tag, "_miso_oe"}, miso_oe, 1'b0);
    check({tag, "_rx_data"}, bus.rx_data, 8'h00);
    check({tag, "_byte_idx"}, bus.byte_idx, 8'h00);
  endtask

  task automatic run_frame_checked(input string tag, input int tail, input int exp_rx,
                                   input int exp_abort);
    int s0, e0, a0, r0, n;
    s0 = n_start; e0 = n_end; a0 = n_abort; r0 = n_rx;
    n = fr_d.size();
    send_frame(tail);
    check({tag, "_frame_start"}, n_start - s0, 1);
    check({tag, "_frame_end"}, n_end - e0, 1);
    check({tag, "_frame_abort"}, n_abort - a0, exp_abort);
    check({tag, "_rx_count"}, n_rx - r0, exp_rx);
    check({tag, "_byte_idx"}, bus.byte_idx, (n > IDX_MAX) ? IDX_MAX : n);
    check({tag, "_exp_empty"}, exp_q.size(), 0);
    check({tag, "_miso_oe_idle"}, miso_oe, 1'b0);
    if (n > 0) check({tag, "_rx_data_held"}, bus.rx_data, fr_d[n-1]);
  endtask

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    int s0, r0, e0, n, tail;
    bus.tx_data = 8'h00;
    tbl[0] = '{3, 8'h02, 8'h34, 8'h12, 0, 3, 0};
    tbl[1] = '{0, 8'h00, 8'h00, 8'h00, 5, 0, 1};
    tbl[2] = '{1, 8'hFF, 8'h00, 8'h00, 0, 1, 0};
    tbl[3] = '{2, 8'hA5, 8'h5A, 8'h00, 3, 2, 1};
    tbl[4] = '{1, 8'h00, 8'h00, 8'h00, 7, 1, 1};

    // Reset with CS idle high
    reset = 1'b1;
    cyc(4);
    check_reset_outputs("reset");
    reset = 1'b0;
    cyc(8);

    // Directed frames
    for (int v = 0; v < 5; v++) begin
      fill_random(tbl[v].n);
      if (tbl[v].n > 0) fr_d[0] = tbl[v].d0;
      if (tbl[v].n > 1) fr_d[1] = tbl[v].d1;
      if (tbl[v].n > 2) fr_d[2] = tbl[v].d2;
      run_frame_checked($sformatf("vec%0d", v), tbl[v].tail, tbl[v].exp_rx, tbl[v].exp_abort);
    end

    // Reply shifting: A5 at frame start, 3C on the byte boundary
    fill_random(2);
    fr_r[0] = 8'hA5;
    fr_r[1] = 8'h3C;
    run_frame_checked("miso", 0, 2, 0);

    // Randomised frames
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 4);
      tail = $urandom_range(0, 7);
      fill_random(n);
      run_frame_checked($sformatf("rand%0d", r), tail, n, (tail != 0) ? 1 : 0);
    end

    // CS held low through reset release: the bus must stay ignored
    CS = 1'b0;
    reset = 1'b1;
    cyc(4);
    reset = 1'b0;
    cyc(5);
    s0 = n_start; r0 = n_rx;
    for (int i = 0; i < 8; i++) sck_bit(1'($urandom), 1'b0, 1'b0);
    cyc(4);
    check("cslow_no_start", n_start - s0, 0);
    check("cslow_no_rx", n_rx - r0, 0);
    check("cslow_miso_oe", miso_oe, 1'b0);
    CS = 1'b1;
    cyc(8);
    fill_random(1);
    fr_d[0] = 8'h07;
    run_frame_checked("cslow_recover", 0, 1, 0);

    // Long frame: byte_idx saturates, rx_first only on byte 0
    fill_random(300);
    run_frame_checked("long", 0, 300, 0);

    // Reset in the middle of byte 2
    fill_random(2);
    fr_d[0] = 8'h11;
    bus.tx_data = fr_r[0];
    tx_q.delete();
    tx_q.push_back(fr_r[1]);
    r0 = n_rx;
    CS = 1'b0;
    cyc(6);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) exp_q.push_back({1'b1, 8'd1, 8'h11});
      sck_bit(fr_d[0][7-i], fr_r[0][7-i], 1'b1);
    end
    for (int i = 0; i < 4; i++) sck_bit(fr_d[1][7-i], fr_r[1][7-i], 1'b1);
    reset = 1'b1;
    cyc(3);
    check_reset_outputs("midreset");
    reset = 1'b0;
    e0 = n_end;
    for (int i = 4; i < 8; i++) sck_bit(fr_d[1][7-i], 1'b0, 1'b0);
    cyc(4);
    CS = 1'b1;
    cyc(8);
    check("midreset_rx_count", n_rx - r0, 1);
    check("midreset_no_end", n_end - e0, 0);
    check("midreset_exp_empty", exp_q.size(), 0);
    fill_random(1);
    fr_d[0] = 8'h3C;
    run_frame_checked("midreset_recover", 0, 1, 0);

    check("rx_tx_load_overlap", n_overlap, 0);
    check("abort_without_end", n_abort_alone, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
SPI slave front end (mode 0: CPOL=0, CPHA=0, MSB first) between the ESP32 SPI pins and the FPGA command decoder, which issues bram_poke, bram_peek, dbus_read, dbus_write and the other commands. It oversamples SCK/CS/MOSI on the 100 MHz system clock and delivers received bytes as single-cycle strobes with frame position. It serialises reply bytes onto MISO and reports frame start, end and abort events.

Parameters:
SYNC_STAGES, 2, synchroniser flops per input pin (min 2)
IDX_W, 8, width of in-frame byte index (saturating)

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  synchronous, active-high reset
SCK  in  1  SPI clock pin, asynchronous
MOSI  in  1  SPI data-in pin, asynchronous
CS  in  1  SPI chip select pin, active low, asynchronous
MISO  out  1  serial reply data; top level tristates it using miso_oe
miso_oe  out  1  high while CS is active (synchronised)
rx_valid  out  1  one-cycle strobe: rx_data holds a complete byte
rx_data  out  8  last complete received byte; held until next rx_valid
rx_first  out  1  qualifies rx_valid: byte is index 0 of the frame
byte_idx  out  IDX_W  bytes completed in the current frame
tx_data  in  8  next reply byte; sampled when tx_load is high
tx_load  out  1  one-cycle strobe: tx_data captured into the shifter
frame_start  out  1  one-cycle strobe on CS assert
frame_end  out  1  one-cycle strobe on CS deassert
frame_abort  out  1  one-cycle strobe with frame_end when the frame ends mid-byte

Behaviour:
- Reset values: all strobes 0, MISO 0, miso_oe 0, rx_data 0, byte_idx 0, bit counter 0, armed 0.
- Synchroniser reset values: SCK=0, CS=1, MOSI=0.
- Each pin passes through SYNC_STAGES flops plus one history flop. Edges are detected on the last two stages.
- Latency: pin edge to internal edge pulse is SYNC_STAGES+1 clk.
- SCK high and SCK low must each last at least SYNC_STAGES+2 clk. At 100 MHz the supported SCK is 12.5 MHz max.
- armed: set on any cycle where synced CS is high; cleared only by reset.
- If CS is already low when reset is released, no frame starts until CS has been seen high and then low again.
- cs_active = armed & ~cs_sync.
- frame_start: pulses on a CS 1->0 edge while armed.
- On frame_start:
  - clear bit counter and byte_idx
  - load the TX shifter from tx_data
  - pulse tx_load in the same cycle
- SCK rising edge while cs_active:
  - rx_shift <= {rx_shift[6:0], mosi_sync}
  - bitcnt <= bitcnt+1 (3-bit, wraps)
- Byte completion: when the rising edge hits bitcnt==7, then on the next clk:
  - rx_data <= completed byte
  - rx_valid=1
  - rx_first=(byte_idx==0)
  - byte_idx increments, saturating at 2^IDX_W-1
- SCK falling edge while cs_active:
  - if bitcnt==0 (byte boundary), load the shifter from tx_data and pulse tx_load
  - otherwise shift left, filling with 0
- In mode 0 the first edge of a frame is rising, so a falling edge with bitcnt==0 occurs only after a completed byte.
- MISO = tx_shift[7]; miso_oe = cs_active.
- CS 0->1 edge:
  - frame_end pulses
  - frame_abort pulses in the same cycle if bitcnt!=0
  - partial bits are discarded and no rx_valid is issued
  - bit counter is cleared
- Simultaneous events:
  - CS deassert edge in the same cycle as an SCK edge: CS wins and the SCK edge is ignored.
  - frame_start and a stale SCK edge in the same cycle: frame_start wins.
- Reset mid-frame: all state returns to reset values and armed=0. The remainder of that frame is ignored.
- rx_valid and tx_load never assert in the same cycle, because they are driven from opposite SCK edges.

Decomposition:
- Shared include spi_defs.vh holds the mode-0 constants and the command opcodes used by the downstream decoder:
  - SET_LED=0, BRAM_POKE=1, BRAM_PEEK=2, DBUS_READ=3, DBUS_WRITE=4, DATA_READY=5, SET_BREAKPOINT=6, CLEAR_BREAKPOINT=7
- One sub-module, pin_sync_edge: parameterised N-stage synchroniser with rise/fall pulse outputs and a reset value parameter. Instantiate it three times.

Test Plan:
- Reset with CS high, then send frame 0x02,0x34,0x12 at SCK=clk/10 -> frame_start once; three rx_valid with rx_data 0x02, 0x34, 0x12; rx_first only on 0x02; byte_idx 3; frame_end; no frame_abort.
- tx_data=0xA5 at frame_start, 0x3C on the second tx_load, 8 then 16 SCK cycles -> MISO bits 10100101 sampled on rising edges, then 00111100; miso_oe low outside the frame.
- CS deasserted after 5 SCK rising edges -> no rx_valid; frame_end and frame_abort in the same cycle; the next frame's first byte 0xFF is received correctly with rx_first=1.
- Hold CS low through reset release, clock 8 bits -> no frame_start, no rx_valid. Then raise and lower CS and send 0x07 -> rx_valid with 0x07.
- Send 300 bytes in one frame with IDX_W=8 -> byte_idx saturates at 255; rx_first only on byte 0; all 300 rx_valid strobes present.
- Assert reset after 4 bits of byte 2 -> all outputs return to reset values; no rx_valid or frame_end for the aborted frame.
